// File: rtl/l2_cache_assoc_pkg.sv
// Shared types and FSM encodings for the set-associative L2 cache.
package l2_cache_assoc_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_cacheline;

  // Byte-offset bits inside a 16-byte line.
  localparam int OFF_W = 4;

  // Controller states, kept as plain constants so older tooling can decode them.
  typedef logic [2:0] l2a_state_t;
  localparam l2a_state_t IDLE    = 3'd0;
  localparam l2a_state_t LOOKUP  = 3'd1;
  localparam l2a_state_t WB      = 3'd2;
  localparam l2a_state_t FILL    = 3'd3;
  localparam l2a_state_t INSTALL = 3'd4;
  localparam l2a_state_t RESP    = 3'd5;

endpackage

// File: rtl/l2_cache_assoc_plru.sv
// Tree-PLRU bookkeeping: WAYS-1 bits per set, heap-numbered nodes 1..WAYS-1.
// A node bit of 0 steers the victim search to the lower half, 1 to the upper half.
module l2_plru_tree
  import l2_cache_assoc_pkg::*;
#(
  parameter int WAYS = 4,
  parameter int SETS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(SETS)-1:0]  set_idx,
  input  logic                     touch_en,
  input  logic [$clog2(WAYS)-1:0]  touch_way,
  output logic [$clog2(WAYS)-1:0]  victim_way
);
  localparam int WAY_W = $clog2(WAYS);

  logic [WAYS-1:1] bits_arr [SETS];
  logic [WAYS-1:1] cur_row;
  logic [WAYS-1:1] next_row;
  logic [WAY_W:0]  vnode;
  logic [WAY_W:0]  tnode;

  // Walk the indexed set's tree to the victim leaf and build the touched row.
  always_comb begin
    cur_row  = bits_arr[set_idx];
    vnode    = (WAY_W+1)'(1);
    for (int l = 0; l < WAY_W; l++) begin
      vnode = {vnode[WAY_W-1:0], cur_row[vnode[WAY_W-1:0]]};
    end
    victim_way = vnode[WAY_W-1:0];

    next_row = cur_row;
    tnode    = (WAY_W+1)'(1);
    for (int l = 0; l < WAY_W; l++) begin
      // Point each node on the used way's path toward the opposite half.
      next_row[tnode[WAY_W-1:0]] = ~touch_way[WAY_W-1-l];
      tnode = {tnode[WAY_W-1:0], touch_way[WAY_W-1-l]};
    end
  end

  // Store the updated row for the indexed set on a touch; reset clears all sets.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) bits_arr[s] <= '0;
    end else if (touch_en) begin
      bits_arr[set_idx] <= next_row;
    end
  end

endmodule

// File: rtl/l2_cache_assoc.sv
// N-way set-associative, write-back, write-allocate L2 with tree-PLRU
// replacement and saturating hit/miss/writeback counters.
//
// Handshake: the arbiter raises mem_read or mem_write (never both) and holds it
// with a stable address/wdata until mem_resp pulses for one cycle; it drops the
// request before the following IDLE cycle. Toward memory, pmem_read/pmem_write
// and pmem_address/pmem_wdata are held stable until a one-cycle pmem_resp.
module l2_cache_assoc
  import l2_cache_assoc_pkg::*;
#(
  parameter int WAYS  = 4,
  parameter int SETS  = 8,
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_read,
  input  logic          mem_write,
  input  lc3b_word      mem_address,
  input  lc3b_cacheline mem_wdata,
  output logic          mem_resp,
  output lc3b_cacheline mem_rdata,
  output logic          pmem_read,
  output logic          pmem_write,
  output lc3b_word      pmem_address,
  output lc3b_cacheline pmem_wdata,
  input  logic          pmem_resp,
  input  lc3b_cacheline pmem_rdata,
  input  logic          perf_clr,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic [CNT_W-1:0] wb_cnt,
  output l2a_state_t    dbg_state
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 16 - OFF_W - IDX_W;
  localparam int WAY_W = $clog2(WAYS);

  l2a_state_t          state;
  logic [15-OFF_W:0]   req_line;
  lc3b_cacheline       req_wdata;
  logic                req_wr;
  logic [WAY_W-1:0]    victim_q;

  logic [TAG_W-1:0]    tag_arr   [WAYS][SETS];
  logic                valid_arr [WAYS][SETS];
  logic                dirty_arr [WAYS][SETS];
  lc3b_cacheline       data_arr  [WAYS][SETS];
  lc3b_cacheline       rdata_q;

  logic [IDX_W-1:0]    req_idx;
  logic [TAG_W-1:0]    req_tag;
  logic                hit, any_inv;
  logic [WAY_W-1:0]    hit_way, inv_way, plru_victim, victim_sel, touch_way;
  logic                hit_wr, fill_wr, inst_wr, touch_en;
  logic [OFF_W-1:0]    unused_off;

  // Accesses are line-granular, so the byte offset is never consulted.
  assign unused_off = mem_address[OFF_W-1:0];

  assign req_idx    = req_line[IDX_W-1:0];
  assign req_tag    = req_line[IDX_W +: TAG_W];
  assign hit_wr     = (state == LOOKUP) && hit && req_wr;
  assign fill_wr    = (state == FILL) && pmem_resp;
  assign inst_wr    = (state == INSTALL);
  assign touch_en   = ((state == LOOKUP) && hit) || fill_wr || inst_wr;
  assign touch_way  = (state == LOOKUP) ? hit_way : victim_q;
  assign victim_sel = any_inv ? inv_way : plru_victim;

  assign mem_resp   = (state == RESP);
  assign mem_rdata  = rdata_q;
  assign pmem_read  = (state == FILL);
  assign pmem_write = (state == WB);
  assign pmem_wdata = data_arr[victim_q][req_idx];
  assign dbg_state  = state;

  l2_plru_tree #(.WAYS(WAYS), .SETS(SETS)) u_plru (
    .clk        (clk),
    .rst        (rst),
    .set_idx    (req_idx),
    .touch_en   (touch_en),
    .touch_way  (touch_way),
    .victim_way (plru_victim)
  );

  // Tag match across the set plus lowest-index invalid way (descending scan).
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    any_inv = 1'b0;
    inv_way = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (valid_arr[w][req_idx] && (tag_arr[w][req_idx] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_arr[w][req_idx]) begin
        any_inv = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
  end

  // Physical address: victim line during writeback, requested line during fill.
  always_comb begin
    pmem_address = '0;
    if (state == WB)   pmem_address = {tag_arr[victim_q][req_idx], req_idx, 4'h0};
    if (state == FILL) pmem_address = {req_tag, req_idx, 4'h0};
  end

  // Controller FSM; reset drops any in-flight request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      victim_q <= '0;
    end else begin
      case (state)
        IDLE:    if (mem_read || mem_write) state <= LOOKUP;
        LOOKUP: begin
          if (hit) begin
            state <= RESP;
          end else begin
            victim_q <= victim_sel;
            if (valid_arr[victim_sel][req_idx] && dirty_arr[victim_sel][req_idx]) state <= WB;
            else if (req_wr) state <= INSTALL;
            else             state <= FILL;
          end
        end
        WB:      if (pmem_resp) state <= req_wr ? INSTALL : FILL;
        FILL:    if (pmem_resp) state <= RESP;
        INSTALL: state <= RESP;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Request capture in IDLE; held for the whole transaction.
  always_ff @(posedge clk) begin
    if (state == IDLE && (mem_read || mem_write)) begin
      req_line  <= mem_address[15:OFF_W];
      req_wdata <= mem_wdata;
      req_wr    <= mem_write;
    end
  end

  // Valid/dirty bookkeeping: write hit dirties, fill is clean, install is dirty.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < WAYS; w++) begin
        for (int s = 0; s < SETS; s++) begin
          valid_arr[w][s] <= 1'b0;
          dirty_arr[w][s] <= 1'b0;
        end
      end
    end else begin
      if (hit_wr) dirty_arr[hit_way][req_idx] <= 1'b1;
      if (fill_wr) begin
        valid_arr[victim_q][req_idx] <= 1'b1;
        dirty_arr[victim_q][req_idx] <= 1'b0;
      end
      if (inst_wr) begin
        valid_arr[victim_q][req_idx] <= 1'b1;
        dirty_arr[victim_q][req_idx] <= 1'b1;
      end
    end
  end

  // Tag/data storage and the read-return register.
  always_ff @(posedge clk) begin
    if (state == LOOKUP && hit) rdata_q <= data_arr[hit_way][req_idx];
    if (hit_wr) data_arr[hit_way][req_idx] <= req_wdata;
    if (fill_wr) begin
      data_arr[victim_q][req_idx] <= pmem_rdata;
      tag_arr[victim_q][req_idx]  <= req_tag;
      rdata_q                     <= pmem_rdata;
    end
    if (inst_wr) begin
      data_arr[victim_q][req_idx] <= req_wdata;
      tag_arr[victim_q][req_idx]  <= req_tag;
    end
  end

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c, input logic inc);
    return (inc && (c != '1)) ? c + CNT_W'(1) : c;
  endfunction

  // Saturating performance counters; a clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || perf_clr) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
    end else begin
      hit_cnt  <= bump(hit_cnt,  (state == LOOKUP) && hit);
      miss_cnt <= bump(miss_cnt, (state == LOOKUP) && !hit);
      wb_cnt   <= bump(wb_cnt,   (state == WB) && pmem_resp);
    end
  end

endmodule

// File: tb/tb_l2_cache_assoc.sv
// Directed bench for l2_cache_assoc (WAYS=4, SETS=8, CNT_W=4) with a
// behavioural physical memory that can stall its response.
module tb_l2_cache_assoc;
  import l2_cache_assoc_pkg::*;

  localparam int CW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          mem_read = 1'b0, mem_write = 1'b0;
  lc3b_word      mem_address = '0;
  lc3b_cacheline mem_wdata = '0;
  logic          mem_resp;
  lc3b_cacheline mem_rdata;
  logic          pmem_read, pmem_write;
  lc3b_word      pmem_address;
  lc3b_cacheline pmem_wdata;
  logic          pmem_resp = 1'b0;
  lc3b_cacheline pmem_rdata = '0;
  logic          perf_clr = 1'b0;
  logic [CW-1:0] hit_cnt, miss_cnt, wb_cnt;
  l2a_state_t    dbg_state;

  l2_cache_assoc #(.WAYS(4), .SETS(8), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
    .perf_clr(perf_clr), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [127:0] exp_q[$];
  logic [15:0]  rd_addr_q[$];
  logic [15:0]  wr_addr_q[$];
  logic [127:0] wr_data_q[$];
  logic [127:0] mem_model [logic [15:0]];
  int   pmem_delay = 2;
  logic stall_chk = 1'b0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  function automatic logic [127:0] pat(input logic [15:0] a);
    return {a, ~a, a + 16'd1, a + 16'd2, 16'hC0DE, a ^ 16'h5A5A, 16'h0F0F, a};
  endfunction

  function automatic logic [127:0] line_of(input logic [15:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return pat(a);
  endfunction

  // ---------------- physical memory model ----------------
  logic         pm_busy = 1'b0;
  int           pm_cnt = 0;
  logic [15:0]  pm_addr = '0;
  logic [127:0] pm_data = '0;

  initial begin
    forever begin
      @(negedge clk);
      pmem_resp = 1'b0;
      if (pmem_read || pmem_write) begin
        check("pmem_exclusive", pmem_read && pmem_write, 1'b0);
        if (!pm_busy) begin
          pm_busy = 1'b1;
          pm_cnt  = 0;
          pm_addr = pmem_address;
          pm_data = pmem_wdata;
        end else if (stall_chk) begin
          check("stall_addr", pmem_address, pm_addr);
          if (pmem_write) check("stall_wdata", pmem_wdata, pm_data);
          check("stall_no_resp", mem_resp, 1'b0);
        end
        if (pm_cnt >= pmem_delay) begin
          pmem_resp = 1'b1;
          pm_busy   = 1'b0;
          if (pmem_write) begin
            mem_model[pmem_address] = pmem_wdata;
            wr_addr_q.push_back(pmem_address);
            wr_data_q.push_back(pmem_wdata);
          end else begin
            pmem_rdata = line_of(pmem_address);
            rd_addr_q.push_back(pmem_address);
          end
        end else begin
          pm_cnt++;
        end
      end else begin
        pm_busy = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_access(input logic wr, input logic [15:0] a, input logic [127:0] wd,
                           output logic [127:0] rd, output int lat, output logic ok);
    rd = '0; lat = 0; ok = 1'b0;
    @(negedge clk);
    mem_read = !wr; mem_write = wr; mem_address = a; mem_wdata = wd;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      lat++;
      if (mem_resp) begin
        rd = mem_rdata;
        ok = 1'b1;
        break;
      end
    end
    mem_read = 1'b0; mem_write = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pulse_clr();
    @(negedge clk); perf_clr = 1'b1;
    @(negedge clk); perf_clr = 1'b0;
  endtask

  typedef struct {
    logic         wr;
    logic [15:0]  addr;
    logic [127:0] wdata;
    logic [127:0] exp_rdata;
    logic         exp_hit;
    int           exp_rd;
    int           exp_wr;
    logic [15:0]  exp_wb_addr;
    logic [127:0] exp_wb_data;
  } vec_t;

  function automatic vec_t mk(logic wr, logic [15:0] a, logic [127:0] wd, logic [127:0] er,
                              logic eh, int erd, int ewr, logic [15:0] wba, logic [127:0] wbd);
    vec_t v;
    v.wr = wr; v.addr = a; v.wdata = wd; v.exp_rdata = er; v.exp_hit = eh;
    v.exp_rd = erd; v.exp_wr = ewr; v.exp_wb_addr = wba; v.exp_wb_data = wbd;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    logic [127:0] rd;
    int lat, rd0, wr0;
    logic ok;
    logic [CW-1:0] h0, m0, dh, dm;
    rd0 = rd_addr_q.size(); wr0 = wr_addr_q.size();
    h0 = hit_cnt; m0 = miss_cnt;
    if (!v.wr) exp_q.push_back(v.exp_rdata);
    do_access(v.wr, v.addr, v.wdata, rd, lat, ok);
    check({tag, "_done"}, ok, 1'b1);
    if (!v.wr) check({tag, "_rdata"}, rd, exp_q.pop_front());
    if (v.exp_hit) check({tag, "_hit_latency"}, lat, 2);
    check({tag, "_pmem_reads"}, rd_addr_q.size() - rd0, v.exp_rd);
    check({tag, "_pmem_writes"}, wr_addr_q.size() - wr0, v.exp_wr);
    if (v.exp_rd > 0 && rd_addr_q.size() > rd0)
      check({tag, "_fill_addr"}, rd_addr_q[$], {v.addr[15:4], 4'h0});
    if (v.exp_wr > 0 && wr_addr_q.size() > wr0) begin
      check({tag, "_wb_addr"}, wr_addr_q[$], v.exp_wb_addr);
      check({tag, "_wb_data"}, wr_data_q[$], v.exp_wb_data);
    end
    dh = hit_cnt - h0; dm = miss_cnt - m0;
    check({tag, "_hit_delta"}, dh, v.exp_hit ? 1 : 0);
    check({tag, "_miss_delta"}, dm, v.exp_hit ? 0 : 1);
  endtask

  // ---------------- test sequence ----------------
  localparam logic [127:0] LA = {8{16'hAAAA}};
  localparam logic [127:0] LB = {8{16'hB00B}};

  vec_t tbl[14];
  vec_t stl[5];

  initial begin
    logic [127:0] rd;
    int lat;
    logic ok;

    // Main table: cold/hit in set 3, write-allocate in set 4, PLRU writeback in set 0.
    tbl[0]  = mk(0, 16'h1230, '0, pat(16'h1230), 0, 1, 0, '0, '0);
    tbl[1]  = mk(0, 16'h1230, '0, pat(16'h1230), 1, 0, 0, '0, '0);
    tbl[2]  = mk(1, 16'h2040, LA, '0,            0, 0, 0, '0, '0);
    tbl[3]  = mk(0, 16'h2040, '0, LA,            1, 0, 0, '0, '0);
    tbl[4]  = mk(1, 16'h0000, LB, '0,            0, 0, 0, '0, '0);
    tbl[5]  = mk(0, 16'h0080, '0, pat(16'h0080), 0, 1, 0, '0, '0);
    tbl[6]  = mk(0, 16'h0100, '0, pat(16'h0100), 0, 1, 0, '0, '0);
    tbl[7]  = mk(0, 16'h0180, '0, pat(16'h0180), 0, 1, 0, '0, '0);
    tbl[8]  = mk(0, 16'h0080, '0, pat(16'h0080), 1, 0, 0, '0, '0);
    tbl[9]  = mk(0, 16'h0100, '0, pat(16'h0100), 1, 0, 0, '0, '0);
    tbl[10] = mk(0, 16'h0180, '0, pat(16'h0180), 1, 0, 0, '0, '0);
    tbl[11] = mk(0, 16'h0200, '0, pat(16'h0200), 0, 1, 1, 16'h0000, LB);
    tbl[12] = mk(0, 16'h0000, '0, LB,            0, 1, 0, '0, '0);
    tbl[13] = mk(0, 16'h2040, '0, LA,            1, 0, 0, '0, '0);

    // Set 5: four dirty installs, then a miss that writes back way 0 under a long stall.
    stl[0] = mk(1, 16'h0050, '0, '0, 0, 0, 0, '0, '0);
    stl[1] = mk(1, 16'h00D0, '0, '0, 0, 0, 0, '0, '0);
    stl[2] = mk(1, 16'h0150, '0, '0, 0, 0, 0, '0, '0);
    stl[3] = mk(1, 16'h01D0, '0, '0, 0, 0, 0, '0, '0);
    stl[4] = mk(0, 16'h0250, '0, pat(16'h0250), 0, 1, 1, 16'h0050, {8{16'hE000}});
    for (int i = 0; i < 4; i++) stl[i].wdata = {8{16'hE000 + 16'(i)}};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    check("rst_state", dbg_state, IDLE);
    check("rst_mem_resp", mem_resp, 1'b0);
    check("rst_pmem_read", pmem_read, 1'b0);
    check("rst_pmem_write", pmem_write, 1'b0);
    check("rst_pmem_address", pmem_address, 16'h0);
    check("rst_hit_cnt", hit_cnt, 0);
    check("rst_miss_cnt", miss_cnt, 0);
    check("rst_wb_cnt", wb_cnt, 0);

    for (int i = 0; i < 14; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));
    check("tbl_hit_total", hit_cnt, 6);
    check("tbl_miss_total", miss_cnt, 8);
    check("tbl_wb_total", wb_cnt, 1);

    // Long pmem stall during writeback and fill.
    pulse_clr();
    for (int i = 0; i < 4; i++) run_vec(stl[i], $sformatf("stl%0d", i));
    pmem_delay = 20;
    stall_chk  = 1'b1;
    run_vec(stl[4], "stl4");
    stall_chk  = 1'b0;
    pmem_delay = 2;
    check("stall_wb_cnt", wb_cnt, 1);
    check("stall_miss_cnt", miss_cnt, 5);

    // Saturation, then clear coinciding with a hit.
    pulse_clr();
    for (int i = 0; i < 20; i++) begin
      do_access(1'b0, 16'h1230, '0, rd, lat, ok);
      check("sat_loop_done", ok, 1'b1);
    end
    check("sat_hit_cnt", hit_cnt, 4'hF);
    @(negedge clk);
    mem_read = 1'b1; mem_address = 16'h1230;
    @(posedge clk); #1;
    check("clr_in_lookup", dbg_state, LOOKUP);
    @(negedge clk); perf_clr = 1'b1;
    @(posedge clk); #1;
    perf_clr = 1'b0;
    mem_read = 1'b0;
    check("clr_beats_hit", hit_cnt, 0);
    check("clr_hit_resp", mem_resp, 1'b1);
    @(posedge clk); #1;
    check("clr_stays_zero", hit_cnt, 0);

    // Reset in the middle of a fill.
    pmem_delay = 10;
    @(negedge clk);
    mem_read = 1'b1; mem_address = 16'h3000;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (pmem_read) begin ok = 1'b1; break; end
    end
    check("rstfill_reached_fill", ok, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1; mem_read = 1'b0;
    @(posedge clk); #1;
    check("rstfill_pmem_read", pmem_read, 1'b0);
    check("rstfill_pmem_write", pmem_write, 1'b0);
    check("rstfill_mem_resp", mem_resp, 1'b0);
    check("rstfill_state", dbg_state, IDLE);
    check("rstfill_miss_cnt", miss_cnt, 0);
    @(negedge clk); rst = 1'b0;
    pmem_delay = 2;
    repeat (3) @(posedge clk);
    run_vec(mk(0, 16'h1230, '0, pat(16'h1230), 0, 1, 0, '0, '0), "post_rst_1230");
    run_vec(mk(0, 16'h2040, '0, pat(16'h2040), 0, 1, 0, '0, '0), "post_rst_2040");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
